stage_collide: RTL and testbench
================================

STAGE_COLLIDE -- requirements
Module: stage_collide

Interface
REQ-001 clk  input  1  system clock; single clock domain.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 state  input  4  game state from the play controller (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8).
REQ-004 player_x  input  9  player X pixel position.
REQ-005 player_y  input  9  player Y pixel position.
REQ-006 key_find  output  2  keys collected in the current stage, 0..3.
REQ-007 isDark  output  1  room is unlit; light switch not yet reached.
REQ-008 pass  output  1  one-cycle pulse when the door is reached with all keys.
REQ-009 fail  output  1  one-cycle pulse when the boss catches the player.
REQ-010 boss_x, boss_y  output  9 each  boss position.
REQ-011 obj_x, obj_y  output  9 each  position of the current target object.
REQ-012 Parameter HIT_R, default 8: half-width of the object hit box in pixels.
REQ-013 Parameter BOSS_R, default 6: half-width of the boss hit box in pixels.
REQ-014 Parameter BOSS_DIV, default 2_500_000: clock cycles per boss step; the bench overrides it to 4.

Function
REQ-015 Stage entry: the cycle in which state equals STAGE1, STAGE2 or STAGE3 and the previous state did not.
- At that edge: key_find=0.
- isDark=1 for STAGE2, otherwise 0.
- boss at home (280,40).
- step counter=0.
- done flag cleared.
REQ-016 Target selection, combinational from registered values:
- if isDark, the light;
- else if key_find<3, key[key_find] of the current stage;
- else the door.
- obj_x/obj_y shall present the selected target.
REQ-017 Hit test: |player_x-obj_x| < HIT_R and |player_y-obj_y| < HIT_R.
- Unsigned 9-bit absolute difference, computed as larger minus smaller; no wrap.
REQ-018 A hit is sampled at the clock edge; its effect is visible one cycle after player_x/player_y enter the box. Effect by target:
- light: isDark<=0.
- key: key_find<=key_find+1, saturating at 3.
- door: pass=1 for exactly one cycle and done<=1.
REQ-019 While done=1, no further pass, key, light, boss or fail updates occur until the next stage entry.
REQ-020 Only one target changes per cycle. If the player sits inside consecutive targets, they are consumed on consecutive cycles.
REQ-021 Boss movement, STAGE3 only:
- The step counter counts 0..BOSS_DIV-1 and wraps.
- On wrap, boss_x and boss_y each move 1 pixel toward player_x and player_y.
- A coordinate that is equal does not move.
REQ-022 Boss contact in STAGE3, when not done: |player-boss| < BOSS_R on both axes.
- fail=1 for one cycle and done<=1.
REQ-023 If the door hit and boss contact occur in the same cycle, pass wins and fail stays 0.
REQ-024 In STAGE1/STAGE2 the boss is held at home, and fail never asserts.
REQ-025 Outside STAGE1/2/3:
- key_find, isDark, pass and fail are 0.
- boss at home.
- counter 0.
- obj outputs show the stage1 key[0].
REQ-026 If state jumps directly between two different stage values, that counts as a new stage entry.

Reset
REQ-027 On rst at a clock edge:
- key_find=0, isDark=0, pass=0, fail=0.
- boss_x=280, boss_y=40.
- counter=0, done=0.
- previous-state register = TITLE.
REQ-028 rst asserted mid-stage overrides every other update in that cycle.
REQ-029 After rst deasserts while state is a stage value, that cycle is treated as a stage entry.

Structure
REQ-030 A shared package holds:
- the state encoding constants;
- per-stage object coordinate tables;
- the boss home position.
REQ-031 Stage1 objects:
- keys (100,60), (200,150), (260,90);
- door (300,130).
REQ-032 Stage2 objects:
- light (60,40);
- keys (120,40), (160,180), (240,60);
- door (300,60).
REQ-033 Stage3 objects:
- keys (80,180), (180,40), (260,180);
- door (300,110).
REQ-034 One sub-module, box_hit, computes the combinational absolute-difference window test. It is instantiated twice: object and boss.

Verification
REQ-035 Reset, then state=2 with player at (40,130) -> key_find=0, isDark=0, obj=(100,60), pass=0.
REQ-036 STAGE1: player at (100,60), then (200,150), then (260,90) -> key_find steps 1, 2, 3, each one cycle after arrival; obj then = (300,130).
REQ-037 STAGE1 with key_find=3, player at (305,125) -> pass high exactly one cycle; no second pulse while the player stays.
REQ-038 STAGE2 entry -> isDark=1, obj=(60,40); player at (58,42) -> isDark=0 next cycle, obj=(120,40).
REQ-039 STAGE3 with BOSS_DIV=4, player at (200,100) -> boss moves to (279,41) after 4 cycles; boss placed adjacent to player -> fail one-cycle pulse, then frozen.
REQ-040 STAGE3 with door hit and boss contact in the same cycle -> pass=1, fail=0; rst mid-stage -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/stage_collide_pkg.sv
// Shared definitions for stage collision logic: game state encoding, per-stage
// object coordinate tables and boss home position.
package stage_collide_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8
  } game_state_e;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
  } point_t;

  typedef enum logic [1:0] {TGT_LIGHT, TGT_KEY, TGT_DOOR} tgt_e;

  localparam point_t BOSS_HOME = '{x: 9'd280, y: 9'd40};
  localparam point_t LIGHT_POS = '{x: 9'd60, y: 9'd40};

  function automatic logic is_stage(input logic [3:0] st);
    return (st == ST_STAGE1) || (st == ST_STAGE2) || (st == ST_STAGE3);
  endfunction

  // Stage index into the coordinate tables: 0 = stage1, 1 = stage2, 2 = stage3.
  function automatic logic [1:0] stage_idx(input logic [3:0] st);
    logic [1:0] idx;
    case (st)
      ST_STAGE2: idx = 2'd1;
      ST_STAGE3: idx = 2'd2;
      default:   idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic point_t key_pos(input logic [1:0] stg, input logic [1:0] idx);
    point_t p;
    case ({stg, idx})
      4'b00_00: p = '{9'd100, 9'd60};
      4'b00_01: p = '{9'd200, 9'd150};
      4'b00_10: p = '{9'd260, 9'd90};
      4'b01_00: p = '{9'd120, 9'd40};
      4'b01_01: p = '{9'd160, 9'd180};
      4'b01_10: p = '{9'd240, 9'd60};
      4'b10_00: p = '{9'd80,  9'd180};
      4'b10_01: p = '{9'd180, 9'd40};
      4'b10_10: p = '{9'd260, 9'd180};
      default:  p = '{9'd100, 9'd60};
    endcase
    return p;
  endfunction

  function automatic point_t door_pos(input logic [1:0] stg);
    point_t p;
    case (stg)
      2'd1:    p = '{9'd300, 9'd60};
      2'd2:    p = '{9'd300, 9'd110};
      default: p = '{9'd300, 9'd130};
    endcase
    return p;
  endfunction

  function automatic logic [8:0] step_toward(input logic [8:0] cur, input logic [8:0] tgt);
    logic [8:0] nxt;
    if (cur < tgt)      nxt = cur + 9'd1;
    else if (cur > tgt) nxt = cur - 9'd1;
    else                nxt = cur;
    return nxt;
  endfunction

endpackage

// File: rtl/stage_collide_box_hit.sv
// Combinational square-window test: both axis distances strictly below R.
module box_hit #(
  parameter int unsigned R = 8
) (
  input  logic [8:0] ax,
  input  logic [8:0] ay,
  input  logic [8:0] bx,
  input  logic [8:0] by,
  output logic       hit
);
  localparam logic [9:0] RW = 10'(R);

  logic [8:0] dx, dy;

  // Larger minus smaller, so the difference never wraps.
  assign dx  = (ax >= bx) ? ax - bx : bx - ax;
  assign dy  = (ay >= by) ? ay - by : by - ay;
  assign hit = ({1'b0, dx} < RW) && ({1'b0, dy} < RW);
endmodule

// File: rtl/stage_collide.sv
// Per-stage object pickup, door/pass detection and stage3 boss chase with
// catch detection.
module stage_collide
  import stage_collide_pkg::*;
#(
  parameter int unsigned HIT_R    = 8,
  parameter int unsigned BOSS_R   = 6,
  parameter int unsigned BOSS_DIV = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  output logic [1:0] key_find,
  output logic       isDark,
  output logic       pass,
  output logic       fail,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [8:0] obj_x,
  output logic [8:0] obj_y
);
  localparam logic [31:0] CNT_LAST = 32'(BOSS_DIV - 1);

  logic [3:0]  prev_state;
  logic [31:0] cnt;
  logic        done;
  logic        in_stage, entry, obj_hit, boss_hit, door_hit;
  logic [1:0]  stg;
  tgt_e        tgt;
  point_t      obj;

  assign in_stage = is_stage(state);
  assign entry    = in_stage && (state != prev_state);
  assign stg      = stage_idx(state);

  always_comb begin
    tgt = TGT_KEY;
    obj = key_pos(2'd0, 2'd0);
    if (in_stage) begin
      if (isDark) begin
        tgt = TGT_LIGHT;
        obj = LIGHT_POS;
      end else if (key_find != 2'd3) begin
        tgt = TGT_KEY;
        obj = key_pos(stg, key_find);
      end else begin
        tgt = TGT_DOOR;
        obj = door_pos(stg);
      end
    end
  end

  assign obj_x = obj.x;
  assign obj_y = obj.y;

  box_hit #(.R(HIT_R)) u_obj_hit (
    .ax(player_x), .ay(player_y), .bx(obj.x), .by(obj.y), .hit(obj_hit)
  );

  box_hit #(.R(BOSS_R)) u_boss_hit (
    .ax(player_x), .ay(player_y), .bx(boss_x), .by(boss_y), .hit(boss_hit)
  );

  assign door_hit = obj_hit && (tgt == TGT_DOOR);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= ST_TITLE;
      key_find   <= 2'd0;
      isDark     <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      boss_x     <= BOSS_HOME.x;
      boss_y     <= BOSS_HOME.y;
      cnt        <= '0;
      done       <= 1'b0;
    end else begin
      prev_state <= state;
      pass       <= 1'b0;
      fail       <= 1'b0;
      if (!in_stage || entry) begin
        key_find <= 2'd0;
        isDark   <= entry && (state == ST_STAGE2);
        boss_x   <= BOSS_HOME.x;
        boss_y   <= BOSS_HOME.y;
        cnt      <= '0;
        done     <= 1'b0;
      end else if (!done) begin
        if (obj_hit) begin
          case (tgt)
            TGT_LIGHT: isDark <= 1'b0;
            TGT_KEY:   key_find <= (key_find == 2'd3) ? 2'd3 : key_find + 2'd1;
            default: begin
              pass <= 1'b1;
              done <= 1'b1;
            end
          endcase
        end
        if (state == ST_STAGE3) begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            boss_x <= step_toward(boss_x, player_x);
            boss_y <= step_toward(boss_y, player_y);
          end else begin
            cnt <= cnt + 32'd1;
          end
          // A door hit in the same cycle takes priority over being caught.
          if (boss_hit && !door_hit) begin
            fail <= 1'b1;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stage_collide.sv
// Scenario bench for stage_collide with a queued expected-output scoreboard.
module tb_stage_collide;
  localparam int W = 41;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state = 4'd0;
  logic [8:0] px = 9'd0;
  logic [8:0] py = 9'd0;
  logic [1:0] key_find;
  logic       is_dark, pass, fail;
  logic [8:0] boss_x, boss_y, obj_x, obj_y;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs;
  int checks = 0;
  int errors = 0;
  int m_bx, m_by, m_cnt;

  always #5 clk = ~clk;

  stage_collide #(.BOSS_DIV(4)) dut (
    .clk(clk), .rst(rst), .state(state), .player_x(px), .player_y(py),
    .key_find(key_find), .isDark(is_dark), .pass(pass), .fail(fail),
    .boss_x(boss_x), .boss_y(boss_y), .obj_x(obj_x), .obj_y(obj_y)
  );

  assign obs = {key_find, is_dark, pass, fail, boss_x, boss_y, obj_x, obj_y};

  function automatic logic [W-1:0] pk(input int kf, input int dk, input int p, input int f,
                                      input int bx, input int by, input int ox, input int oy);
    return {kf[1:0], dk[0], p[0], f[0], bx[8:0], by[8:0], ox[8:0], oy[8:0]};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("kf=%0d dark=%0d pass=%0d fail=%0d boss=(%0d,%0d) obj=(%0d,%0d)",
                     v[40:39], v[38], v[37], v[36], v[35:27], v[26:18], v[17:9], v[8:0]);
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int toward(input int cur, input int tgt);
    return (cur < tgt) ? cur + 1 : (cur > tgt) ? cur - 1 : cur;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Boss reference: moves one pixel toward the player every fourth edge.
  task automatic model_boss_step();
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_bx  = toward(m_bx, int'(px));
      m_by  = toward(m_by, int'(py));
    end else begin
      m_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 4'd0; px = 9'd40; py = 9'd130;
    exp_q.push_back(pk(0, 0, 0, 0, 280, 40, 100, 60));
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset: got %s want %s", fmt(obs), fmt(exp_v));
    end
    rst = 1'b0; state = 4'd2;
    exp_q.push_back(pk(0, 0, 0, 0, 280, 40, 100, 60));
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL stage1_entry: got %s want %s", fmt(obs), fmt(exp_v));
    end
  endtask

  task automatic test_keys();
    int kx[3] = '{100, 200, 260};
    int ky[3] = '{60, 150, 90};
    int ox[3] = '{200, 260, 300};
    int oy[3] = '{150, 90, 130};
    for (int i = 0; i < 3; i++) begin
      px = 9'(kx[i]); py = 9'(ky[i]);
      exp_q.push_back(pk(i + 1, 0, 0, 0, 280, 40, ox[i], oy[i]));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL key_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_door();
    px = 9'd305; py = 9'd125;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(3, 0, (i == 0) ? 1 : 0, 0, 280, 40, 300, 130));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL door_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_light();
    int qx[3] = '{150, 58, 120};
    int qy[3] = '{100, 42, 40};
    state = 4'd4;
    for (int i = 0; i < 3; i++) begin
      px = 9'(qx[i]); py = 9'(qy[i]);
      case (i)
        0:       exp_q.push_back(pk(0, 1, 0, 0, 280, 40, 60, 40));
        1:       exp_q.push_back(pk(0, 0, 0, 0, 280, 40, 120, 40));
        default: exp_q.push_back(pk(1, 0, 0, 0, 280, 40, 160, 180));
      endcase
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL light_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_boss();
    state = 4'd0;
    exp_q.push_back(pk(0, 0, 0, 0, 280, 40, 100, 60));
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL outside_stage: got %s want %s", fmt(obs), fmt(exp_v));
    end
    state = 4'd6; px = 9'd200; py = 9'd100;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pk(0, 0, 0, 0, (i == 4) ? 279 : 280, (i == 4) ? 41 : 40, 80, 180));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL boss_move_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
    px = 9'd281; py = 9'd41;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pk(0, 0, 0, (i == 0) ? 1 : 0, 279, 41, 80, 180));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL boss_catch_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
  endtask

  task automatic test_pass_beats_fail();
    int kx[3] = '{80, 180, 260};
    int ky[3] = '{180, 40, 180};
    int ox[3] = '{180, 260, 300};
    int oy[3] = '{40, 180, 110};
    int n;
    state = 4'd0;
    tick();
    state = 4'd6; px = 9'd80; py = 9'd180;
    m_bx = 280; m_by = 40; m_cnt = 0;
    exp_q.push_back(pk(0, 0, 0, 0, m_bx, m_by, 80, 180));
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL stage3_entry: got %s want %s", fmt(obs), fmt(exp_v));
    end
    for (int i = 0; i < 3; i++) begin
      px = 9'(kx[i]); py = 9'(ky[i]);
      model_boss_step();
      exp_q.push_back(pk(i + 1, 0, 0, 0, m_bx, m_by, ox[i], oy[i]));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL s3_key_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
    // Park just outside the door box until the boss is close enough to catch
    // the player at the door itself.
    px = 9'd300; py = 9'd125; n = 0;
    while (!(absd(300, m_bx) < 6 && absd(110, m_by) < 6) && n < 1000) begin
      model_boss_step();
      exp_q.push_back(pk(3, 0, 0, 0, m_bx, m_by, 300, 110));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL approach_%0d: got %s want %s", n, fmt(obs), fmt(exp_v));
      end
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL approach_timeout: got %0d cycles want < 1000", n);
    end
    px = 9'd300; py = 9'd110;
    model_boss_step();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pk(3, 0, (i == 0) ? 1 : 0, 0, m_bx, m_by, 300, 110));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL pass_wins_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(pk(0, 0, 0, 0, 280, 40, 80, 180));
      tick();
      exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL mid_reset_%0d: got %s want %s", i, fmt(obs), fmt(exp_v));
      end
      rst = 1'b0;
    end
    px = 9'd80; py = 9'd180;
    exp_q.push_back(pk(1, 0, 0, 0, 280, 40, 180, 40));
    tick();
    exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL post_reset_key: got %s want %s", fmt(obs), fmt(exp_v));
    end
  endtask

  initial begin
    test_reset();
    test_keys();
    test_door();
    test_light();
    test_boss();
    test_pass_beats_fail();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
